// File: rtl/frame_serializer.sv
// Ping-pong frame buffer behind the 8-tap FIR core: captures whole N-sample
// frames on the core's strobe and replays them one sample per cycle over valid/ready.
module frame_serializer #(
  parameter int N      = 16,
  parameter int D_BITS = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  data_vld_i,
  input  logic [N*D_BITS-1:0]   data_y_i,
  input  logic                  out_rdy_i,
  output logic                  out_vld_o,
  output logic [D_BITS-1:0]     out_data_o,
  output logic                  out_last_o,
  output logic                  ovf_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef logic [N-1:0][D_BITS-1:0] frame_t;

  // Handshake: a sample moves on a rising edge where out_vld_o && out_rdy_i;
  // while out_vld_o && !out_rdy_i the outputs hold because they depend on
  // registered state only.

  frame_t          bank0_q, bank1_q;
  frame_t          frame_in;
  frame_t          rd_bank;
  logic [1:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            wr_sel_q, wr_sel_d;
  logic            rd_sel_q, rd_sel_d;
  logic            ovf_q, ovf_d;

  logic            xfer;
  logic            frame_release;
  logic            accept;
  logic            drop;

  assign frame_in = frame_t'(data_y_i);

  assign xfer          = (cnt_q != 2'd0) && out_rdy_i;
  assign frame_release = xfer && (idx_q == LAST_IDX);
  // A full buffer can still take a frame when the read side frees a bank on the same edge.
  assign accept        = data_vld_i && ((cnt_q != 2'd2) || frame_release);
  assign drop          = data_vld_i && !accept;

  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    ovf_d    = ovf_q;

    if (xfer) begin
      if (frame_release) begin
        idx_d    = '0;
        rd_sel_d = ~rd_sel_q;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end

    if (accept) begin
      wr_sel_d = ~wr_sel_q;
    end

    if (accept && !frame_release) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!accept && frame_release) begin
      cnt_d = cnt_q - 2'd1;
    end

    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= 2'd0;
      idx_q    <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      ovf_q    <= ovf_d;
    end
  end

  // Bank contents are don't-care after reset; the output mux masks them.
  always_ff @(posedge clk_i) begin
    if (accept && !wr_sel_q) begin
      bank0_q <= frame_in;
    end
    if (accept && wr_sel_q) begin
      bank1_q <= frame_in;
    end
  end

  assign rd_bank    = rd_sel_q ? bank1_q : bank0_q;
  assign out_vld_o  = (cnt_q != 2'd0);
  assign out_data_o = out_vld_o ? rd_bank[idx_q] : '0;
  assign out_last_o = out_vld_o && (idx_q == LAST_IDX);
  assign ovf_o      = ovf_q;

endmodule
